// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between ALU writeback and a load-return FIFO
module rf_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic [4:0]                      alu_add,
  input  logic [XLEN-1:0]                 alu_data,
  input  logic                            lsu_valid,
  output logic                            lsu_ready,
  input  logic [4:0]                      lsu_add,
  input  logic [XLEN-1:0]                 lsu_data,
  output logic                            rf_reg_wr,
  output logic [4:0]                      rf_write_add,
  output logic [XLEN-1:0]                 rf_write_data,
  output logic [31:0]                     pend_mask,
  output logic [$clog2(LQ_DEPTH+1)-1:0]   lq_count
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = $clog2(LQ_DEPTH+1);
  localparam int WW = $clog2(MAX_WAIT+1);
  logic [4:0]      add_q [LQ_DEPTH];
  logic [XLEN-1:0] dat_q [LQ_DEPTH];
  logic [PW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            wr_q_o, out_lq_q;
  logic [4:0]      wa_q, win_add;
  logic [XLEN-1:0] wd_q, win_dat;
  logic            head_v, frc, alu_win, lq_win, push, wr_d;
  logic [31:0]     pend;
  always_comb begin
    head_v    = cnt_q != '0;
    frc       = head_v && wait_q == WW'(MAX_WAIT);
    alu_ready = !frc;
    lsu_ready = cnt_q < CW'(LQ_DEPTH);
    alu_win   = alu_valid && !frc;
    lq_win    = head_v && !alu_win;
    push      = lsu_valid && lsu_ready && lsu_add != '0;
    win_add   = alu_win ? alu_add : add_q[rd_q];
    win_dat   = alu_win ? alu_data : dat_q[rd_q];
    wr_d      = (alu_win || lq_win) && win_add != '0;
    cnt_d     = cnt_q + CW'(push) - CW'(lq_win);
    wait_d    = (!head_v || lq_win) ? '0 : (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + WW'(1);
  end
  // Queued load destinations plus an LQ-sourced write still in the output stage
  always_comb begin
    pend = out_lq_q ? (32'd1 << wa_q) : 32'd0;
    for (int i = 0; i < LQ_DEPTH; i++)
      if (CW'(i) < cnt_q) pend = pend | (32'd1 << add_q[rd_q + PW'(i)]);
    pend_mask = pend & ~32'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      wr_q_o   <= 1'b0;
      out_lq_q <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      wr_q_o   <= wr_d;
      out_lq_q <= lq_win;
      if (push) wr_q <= wr_q + PW'(1);
      if (lq_win) rd_q <= rd_q + PW'(1);
      if (wr_d) begin
        wa_q <= win_add;
        wd_q <= win_dat;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      add_q[wr_q] <= lsu_add;
      dat_q[wr_q] <= lsu_data;
    end
  end
  assign rf_reg_wr     = wr_q_o;
  assign rf_write_add  = wa_q;
  assign rf_write_data = wd_q;
  assign lq_count      = cnt_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed-vector self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        alu_valid = 0, lsu_valid = 0;
  logic [4:0]  alu_add = 0, lsu_add = 0;
  logic [31:0] alu_data = 0, lsu_data = 0;
  logic        alu_ready, lsu_ready, rf_reg_wr;
  logic [4:0]  rf_write_add;
  logic [31:0] rf_write_data, pend_mask;
  logic [2:0]  lq_count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  rf_wb_arbiter #(.XLEN(32), .LQ_DEPTH(4), .MAX_WAIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_add(alu_add), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_add(lsu_add), .lsu_data(lsu_data),
    .rf_reg_wr(rf_reg_wr), .rf_write_add(rf_write_add), .rf_write_data(rf_write_data),
    .pend_mask(pend_mask), .lq_count(lq_count)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    alu_valid = v; alu_add = a; alu_data = d;
  endtask
  task automatic lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lsu_valid = v; lsu_add = a; lsu_data = d;
  endtask
  initial begin
    #3;
    check("rst_wr", rf_reg_wr, 0);
    check("rst_add", rf_write_add, 0);
    check("rst_data", rf_write_data, 0);
    check("rst_pend", pend_mask, 0);
    check("rst_cnt", lq_count, 0);
    check("rst_aready", alu_ready, 1);
    check("rst_lready", lsu_ready, 1);
    #9 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("idle_wr", rf_reg_wr, 0);
      check("idle_aready", alu_ready, 1);
      check("idle_lready", lsu_ready, 1);
      check("idle_pend", pend_mask, 0);
    end
    // ALU-only write and x0 suppression
    alu(1, 5, 32'hDEADBEEF);
    #1 check("alu_ready", alu_ready, 1);
    tick;
    alu(1, 0, 32'h12345678);
    check("alu_wr", rf_reg_wr, 1);
    check("alu_add", rf_write_add, 5);
    check("alu_data", rf_write_data, 32'hDEADBEEF);
    tick;
    alu(0, 0, 0);
    check("x0_wr", rf_reg_wr, 0);
    check("x0_add_hold", rf_write_add, 5);
    check("x0_data_hold", rf_write_data, 32'hDEADBEEF);
    tick;
    // Starvation: one load to x7 against a continuously valid ALU
    alu(1, 1, 32'h100);
    lsu(1, 7, 32'h77);
    tick;
    lsu(0, 0, 0);
    check("st_cnt", lq_count, 1);
    check("st_pend", pend_mask, 32'h80);
    for (int i = 0; i < 3; i++) begin
      alu(1, 1, 32'h101 + i);
      #1 check("st_aready", alu_ready, 1);
      tick;
      check("st_alu_add", rf_write_add, 1);
      check("st_alu_data", rf_write_data, 32'h101 + i);
    end
    check("st_force", alu_ready, 0);
    tick;
    check("st_ld_wr", rf_reg_wr, 1);
    check("st_ld_add", rf_write_add, 7);
    check("st_ld_data", rf_write_data, 32'h77);
    check("st_ld_pend", pend_mask, 32'h80);
    check("st_ld_cnt", lq_count, 0);
    check("st_aready2", alu_ready, 1);
    tick;
    check("st_after_add", rf_write_add, 1);
    check("st_after_pend", pend_mask, 0);
    // Full LQ while the ALU keeps winning
    alu(1, 2, 32'h200);
    for (int i = 0; i < 4; i++) begin
      lsu(1, 5'(10 + i), 32'h1000 * (10 + i));
      #1 check("fl_lready", lsu_ready, 1);
      tick;
      check("fl_alu_add", rf_write_add, 2);
    end
    lsu(1, 14, 32'h1000 * 14);
    #1;
    check("fl_cnt", lq_count, 4);
    check("fl_lready_full", lsu_ready, 0);
    check("fl_pend", pend_mask, 32'h3C00);
    check("fl_force", alu_ready, 0);
    tick;
    check("fl_ld10", rf_write_add, 10);
    check("fl_cnt3", lq_count, 3);
    check("fl_lready_free", lsu_ready, 1);
    tick;
    lsu(0, 0, 0);
    alu(0, 0, 0);
    check("fl_alu_again", rf_write_add, 2);
    check("fl_cnt4", lq_count, 4);
    for (int i = 11; i <= 14; i++) begin
      tick;
      check("fl_order_wr", rf_reg_wr, 1);
      check("fl_order_add", rf_write_add, i);
      check("fl_order_data", rf_write_data, 32'h1000 * i);
    end
    tick;
    check("fl_drain_wr", rf_reg_wr, 0);
    check("fl_drain_cnt", lq_count, 0);
    // Same-register collision
    alu(1, 9, 1);
    lsu(1, 9, 2);
    tick;
    alu(0, 0, 0);
    lsu(0, 0, 0);
    check("co_first", rf_write_data, 1);
    check("co_pend1", pend_mask, 32'h200);
    tick;
    check("co_second_add", rf_write_add, 9);
    check("co_second", rf_write_data, 2);
    check("co_pend2", pend_mask, 32'h200);
    tick;
    check("co_idle", rf_reg_wr, 0);
    check("co_pend3", pend_mask, 0);
    // Async reset with queued loads and a pending write
    alu(1, 3, 32'h300);
    for (int i = 0; i < 3; i++) begin
      lsu(1, 5'(20 + i), 32'h2000 + i);
      tick;
    end
    lsu(0, 0, 0);
    check("ar_cnt_pre", lq_count, 3);
    check("ar_wr_pre", rf_reg_wr, 1);
    #2 rst_n = 0;
    #1;
    check("ar_wr", rf_reg_wr, 0);
    check("ar_cnt", lq_count, 0);
    check("ar_pend", pend_mask, 0);
    check("ar_add", rf_write_add, 0);
    alu(0, 0, 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("ar_nowrite", rf_reg_wr, 0);
    end
    check("ar_cnt_post", lq_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
